// File: rtl/eth_pkg.sv
// Shared Ethernet definitions for the transmit and receive paths:
// framing constants, well-known MAC addresses and the byte-wise CRC-32 step.
package eth_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam int unsigned PREAMBLE_LEN  = 7;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
    localparam logic [31:0] CRC_SEED      = 32'hFFFF_FFFF;

    localparam logic [47:0] OUR_MAC       = 48'h02_00_00_00_00_01;
    localparam logic [47:0] MAC_BROADCAST = 48'hFF_FF_FF_FF_FF_FF;

    // One byte of the reflected IEEE 802.3 CRC, data consumed LSB first.
    function automatic logic [31:0] crc32_lsbf(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ data[i];
            c  = {1'b0, c[31:1]} ^ (fb ? CRC_POLY : 32'h0000_0000);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_tx_if.sv
// Byte-stream handshakes of the frame transmitter: upstream message bytes in,
// PHY bytes out, plus frame status. master = transmitter side, slave = environment.
interface eth_tx_if;

    logic [7:0] payload_byte;
    logic       payload_valid;
    logic       payload_ready;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       frame_done;

    modport master (
        input  payload_byte, payload_valid, tx_ready,
        output payload_ready, tx_byte, tx_valid, busy, frame_done
    );

    modport slave (
        output payload_byte, payload_valid, tx_ready,
        input  payload_ready, tx_byte, tx_valid, busy, frame_done
    );

endinterface

// File: rtl/eth_tx.sv
// Ethernet II transmitter: wraps a length-prefixed message in preamble, SFD,
// header and FCS, one byte per cycle through a single registered output stage.
module eth_tx
    import eth_pkg::*;
#(
    parameter logic [47:0] DST_MAC    = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [47:0] SRC_MAC    = 48'h00_11_22_33_44_66,
    parameter logic [15:0] ETHERTYPE  = 16'h88B5,
    parameter int          IFG_CYCLES = 12
) (
    input  logic      clk,
    input  logic      rst_n,
    eth_tx_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE, PREAMBLE, SFD, HEADER, PAYLOAD, FCS, IFG
    } state_t;

    // The IDLE cycle that samples payload_valid is the last idle cycle of the gap.
    localparam logic [15:0] IFG_LAST = (IFG_CYCLES >= 2) ? 16'(IFG_CYCLES - 2) : 16'd0;
    localparam logic [2:0]  PRE_LAST = 3'(PREAMBLE_LEN);

    state_t      state_r;
    logic [2:0]  cnt_r;
    logic [3:0]  hdr_idx_r;
    logic [16:0] pay_cnt_r;
    logic [15:0] len_r;
    logic [15:0] ifg_cnt_r;
    logic [31:0] crc_r;
    logic [7:0]  tx_byte_r;
    logic        tx_valid_r;
    logic        busy_r;
    logic        frame_done_r;

    logic        out_free_s;
    logic        remain_s;
    logic        last_s;
    logic        payload_ready_s;
    logic        accept_s;
    logic [16:0] total_s;
    logic [7:0]  hdr_byte_s;
    logic [31:0] fcs_s;
    logic [7:0]  fcs_byte_s;

    // Handshake qualifiers, payload length bookkeeping and header/FCS byte muxes.
    always_comb begin
        out_free_s = !tx_valid_r || bus.tx_ready;
        total_s    = {1'b0, len_r} + 17'd2;
        remain_s   = (pay_cnt_r < 17'd2) || (pay_cnt_r < total_s);
        if ((state_r == PAYLOAD) && remain_s && out_free_s) begin
            payload_ready_s = 1'b1;
        end else begin
            payload_ready_s = 1'b0;
        end
        accept_s = payload_ready_s && bus.payload_valid;
        // The end test needs both length bytes; the low one is still on the bus.
        if (pay_cnt_r == 17'd1) begin
            last_s = ({len_r[15:8], bus.payload_byte} == 16'd0);
        end else if (pay_cnt_r >= 17'd2) begin
            last_s = ((pay_cnt_r + 17'd1) == total_s);
        end else begin
            last_s = 1'b0;
        end
        case (hdr_idx_r)
            4'd0:    hdr_byte_s = DST_MAC[47:40];
            4'd1:    hdr_byte_s = DST_MAC[39:32];
            4'd2:    hdr_byte_s = DST_MAC[31:24];
            4'd3:    hdr_byte_s = DST_MAC[23:16];
            4'd4:    hdr_byte_s = DST_MAC[15:8];
            4'd5:    hdr_byte_s = DST_MAC[7:0];
            4'd6:    hdr_byte_s = SRC_MAC[47:40];
            4'd7:    hdr_byte_s = SRC_MAC[39:32];
            4'd8:    hdr_byte_s = SRC_MAC[31:24];
            4'd9:    hdr_byte_s = SRC_MAC[23:16];
            4'd10:   hdr_byte_s = SRC_MAC[15:8];
            4'd11:   hdr_byte_s = SRC_MAC[7:0];
            4'd12:   hdr_byte_s = ETHERTYPE[15:8];
            4'd13:   hdr_byte_s = ETHERTYPE[7:0];
            default: hdr_byte_s = 8'h00;
        endcase
        fcs_s = crc_r ^ 32'hFFFF_FFFF;
        case (cnt_r[1:0])
            2'd0:    fcs_byte_s = fcs_s[7:0];
            2'd1:    fcs_byte_s = fcs_s[15:8];
            2'd2:    fcs_byte_s = fcs_s[23:16];
            2'd3:    fcs_byte_s = fcs_s[31:24];
            default: fcs_byte_s = 8'h00;
        endcase
    end

    // Frame sequencer; each state loads the next byte once the output register frees.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            cnt_r        <= 3'd0;
            hdr_idx_r    <= 4'd0;
            pay_cnt_r    <= 17'd0;
            len_r        <= 16'd0;
            ifg_cnt_r    <= 16'd0;
            crc_r        <= CRC_SEED;
            tx_byte_r    <= 8'h00;
            tx_valid_r   <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.payload_valid) begin
                        tx_byte_r  <= PREAMBLE_BYTE;
                        tx_valid_r <= 1'b1;
                        busy_r     <= 1'b1;
                        cnt_r      <= 3'd1;
                        hdr_idx_r  <= 4'd0;
                        pay_cnt_r  <= 17'd0;
                        state_r    <= PREAMBLE;
                    end
                end
                PREAMBLE: begin
                    if (out_free_s) begin
                        if (cnt_r < PRE_LAST) begin
                            tx_byte_r <= PREAMBLE_BYTE;
                            cnt_r     <= cnt_r + 3'd1;
                        end else begin
                            tx_byte_r <= SFD_BYTE;
                            crc_r     <= CRC_SEED;
                            state_r   <= SFD;
                        end
                    end
                end
                SFD, HEADER: begin
                    if (out_free_s) begin
                        tx_byte_r <= hdr_byte_s;
                        crc_r     <= crc32_lsbf(crc_r, hdr_byte_s);
                        hdr_idx_r <= hdr_idx_r + 4'd1;
                        // Enter PAYLOAD while the last header byte is still queued: no bubble.
                        if (hdr_idx_r == 4'd13) begin
                            state_r <= PAYLOAD;
                        end else begin
                            state_r <= HEADER;
                        end
                    end
                end
                PAYLOAD: begin
                    if (accept_s) begin
                        tx_byte_r  <= bus.payload_byte;
                        tx_valid_r <= 1'b1;
                        crc_r      <= crc32_lsbf(crc_r, bus.payload_byte);
                        pay_cnt_r  <= pay_cnt_r + 17'd1;
                        if (pay_cnt_r == 17'd0) begin
                            len_r[15:8] <= bus.payload_byte;
                        end
                        if (pay_cnt_r == 17'd1) begin
                            len_r[7:0] <= bus.payload_byte;
                        end
                        if (last_s) begin
                            cnt_r   <= 3'd0;
                            state_r <= FCS;
                        end
                    end else if (out_free_s) begin
                        tx_valid_r <= 1'b0;
                    end
                end
                FCS: begin
                    if (out_free_s) begin
                        if (cnt_r != 3'd4) begin
                            tx_byte_r  <= fcs_byte_s;
                            tx_valid_r <= 1'b1;
                            cnt_r      <= cnt_r + 3'd1;
                        end else begin
                            tx_valid_r   <= 1'b0;
                            frame_done_r <= 1'b1;
                            ifg_cnt_r    <= 16'd0;
                            state_r      <= IFG;
                        end
                    end
                end
                IFG: begin
                    if (ifg_cnt_r >= IFG_LAST) begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        ifg_cnt_r <= ifg_cnt_r + 16'd1;
                    end
                end
                default: begin
                    tx_valid_r <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    assign bus.payload_ready = payload_ready_s;
    assign bus.tx_byte       = tx_byte_r;
    assign bus.tx_valid      = tx_valid_r;
    assign bus.busy          = busy_r;
    assign bus.frame_done    = frame_done_r;

endmodule

// File: tb/tb_eth_tx.sv
// Scoreboard bench for eth_tx: expected frames are queued at stimulus time and a
// negedge monitor compares every PHY handshake, holds, gaps and FCS residue.
module tb_eth_tx;

    typedef logic [7:0] bq_t[$];

    localparam int IFG_CYCLES = 12;
    localparam int BOUND      = 400;

    logic clk;
    logic rst_n;

    eth_tx_if bus_if ();

    eth_tx #(
        .DST_MAC   (48'hFF_FF_FF_FF_FF_FF),
        .SRC_MAC   (48'h00_11_22_33_44_66),
        .ETHERTYPE (16'h88B5),
        .IFG_CYCLES(IFG_CYCLES)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    int   n_vec = 0;
    int   n_err = 0;
    int   hs_count = 0;
    int   fd_count = 0;
    bit   toggle_en = 1'b0;
    bq_t  exp_q;
    int   gap_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] tb_crc(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {24'h0, b};
        for (int k = 0; k < 8; k++) begin
            if (c[0]) c = (c >> 1) ^ 32'hEDB8_8320;
            else      c = c >> 1;
        end
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Queue the complete wire image of one frame.
    task automatic push_frame(input bq_t pl);
        bq_t         hdr;
        logic [31:0] c;
        hdr = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
               8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h66, 8'h88, 8'hB5};
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        c = 32'hFFFF_FFFF;
        foreach (hdr[i]) begin exp_q.push_back(hdr[i]); c = tb_crc(c, hdr[i]); end
        foreach (pl[i])  begin exp_q.push_back(pl[i]);  c = tb_crc(c, pl[i]);  end
        c = ~c;
        exp_q.push_back(c[7:0]);
        exp_q.push_back(c[15:8]);
        exp_q.push_back(c[23:16]);
        exp_q.push_back(c[31:24]);
    endtask

    // Upstream driver: optional stall after N accepted bytes, optional early stop.
    task automatic drive(input bq_t pl, input int stall_after, input int stall_len, input int stop_after);
        bit acc;
        int w;
        for (int i = 0; i < pl.size(); i++) begin
            if (stop_after >= 0 && i == stop_after) break;
            bus_if.payload_byte  = pl[i];
            bus_if.payload_valid = 1'b1;
            w = 0;
            do begin
                @(negedge clk);
                acc = bus_if.payload_ready;
                @(posedge clk);
                #1;
                w++;
            end while (!acc && w < BOUND);
            if (!acc) begin
                n_vec++;
                n_err++;
                $display("FAIL payload_accept: byte %0d not taken within %0d cycles", i, BOUND);
                break;
            end
            if (i + 1 == stall_after) begin
                bus_if.payload_valid = 1'b0;
                repeat (stall_len) @(posedge clk);
                #1;
            end
        end
        bus_if.payload_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w = 0;
        while ((bus_if.busy || bus_if.tx_valid) && w < BOUND) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("idle_before_frame", {31'd0, bus_if.busy}, 32'd0);
    endtask

    task automatic wait_fd(input string name, input int target);
        int w = 0;
        while (fd_count < target && w < 4 * BOUND) begin
            @(posedge clk);
            #1;
            w++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_frame_done_count"}, fd_count, target);
    endtask

    task automatic run_frame(input string name, input bq_t pl, input int stall_after, input int stall_len);
        int hs0;
        int fd0;
        wait_idle();
        gap_q.delete();
        hs0 = hs_count;
        fd0 = fd_count;
        push_frame(pl);
        drive(pl, stall_after, stall_len, -1);
        wait_fd(name, fd0 + 1);
        chk({name, "_wire_bytes"}, hs_count - hs0, 8 + 14 + pl.size() + 4);
        chk({name, "_sb_drained"}, exp_q.size(), 0);
    endtask

    // Monitor: scoreboard pops, stall hold, idle-gap lengths and FCS residue.
    initial begin
        int          idle_run = 0;
        int          rx_idx = 0;
        logic [31:0] rx_crc = 32'hFFFF_FFFF;
        logic        prev_stall = 1'b0;
        logic [7:0]  prev_byte = 8'h00;
        logic [7:0]  e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rx_idx     = 0;
                idle_run   = 0;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    n_vec++;
                    if (!(bus_if.tx_valid && bus_if.tx_byte == prev_byte)) begin
                        n_err++;
                        $display("FAIL stall_hold: got valid=%0b byte=%0h, expected valid=1 byte=%0h",
                                 bus_if.tx_valid, bus_if.tx_byte, prev_byte);
                    end
                end
                if (bus_if.tx_valid && bus_if.tx_ready) begin
                    hs_count++;
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL tx_byte: got unexpected byte %0h, expected none", bus_if.tx_byte);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus_if.tx_byte !== e) begin
                            n_err++;
                            $display("FAIL tx_byte[%0d]: got %0h, expected %0h", rx_idx, bus_if.tx_byte, e);
                        end
                    end
                    if (rx_idx == 7)      rx_crc = 32'hFFFF_FFFF;
                    else if (rx_idx >= 8) rx_crc = tb_crc(rx_crc, bus_if.tx_byte);
                    rx_idx++;
                end
                if (bus_if.tx_valid) begin
                    if (idle_run > 0) gap_q.push_back(idle_run);
                    idle_run = 0;
                end else begin
                    idle_run++;
                end
                if (bus_if.frame_done) begin
                    fd_count++;
                    n_vec++;
                    if (rx_crc !== 32'hDEBB_20E3) begin
                        n_err++;
                        $display("FAIL fcs_residue: got %0h, expected debb20e3", rx_crc);
                    end
                    rx_idx = 0;
                end
                prev_stall = bus_if.tx_valid && !bus_if.tx_ready;
                prev_byte  = bus_if.tx_byte;
            end
        end
    end

    // tx_ready toggler for the backpressure test.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (toggle_en) bus_if.tx_ready = ~bus_if.tx_ready;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t         pl3;
        bq_t         pl0x2;
        bq_t         pl0;
        bq_t         pl5;
        logic [31:0] c;
        int          fd0;
        int          hs0;

        pl3   = {8'h00, 8'h03, 8'h41, 8'h01, 8'h02};
        pl0   = {8'h00, 8'h00};
        pl0x2 = {8'h00, 8'h00, 8'h00, 8'h00};
        pl5   = {8'h00, 8'h05, 8'hFF, 8'h00, 8'hA5, 8'h5A, 8'h7E};

        rst_n                = 1'b0;
        bus_if.payload_byte  = 8'h00;
        bus_if.payload_valid = 1'b0;
        bus_if.tx_ready      = 1'b1;
        #12;
        chk("reset_tx_byte",       {24'd0, bus_if.tx_byte},       32'd0);
        chk("reset_tx_valid",      {31'd0, bus_if.tx_valid},      32'd0);
        chk("reset_payload_ready", {31'd0, bus_if.payload_ready}, 32'd0);
        chk("reset_busy",          {31'd0, bus_if.busy},          32'd0);
        chk("reset_frame_done",    {31'd0, bus_if.frame_done},    32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        c = 32'hFFFF_FFFF;
        for (int i = 0; i < 9; i++) c = tb_crc(c, 8'h31 + 8'(i));
        chk("crc_tb_123456789", ~c, 32'hCBF4_3926);
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < 9; i++) c = eth_pkg::crc32_lsbf(c, 8'h31 + 8'(i));
        chk("crc_pkg_123456789", ~c, 32'hCBF4_3926);

        run_frame("l3", pl3, -1, 0);

        toggle_en = 1'b1;
        run_frame("l3_toggle", pl3, -1, 0);
        toggle_en       = 1'b0;
        bus_if.tx_ready = 1'b1;

        run_frame("l3_stall", pl3, 2, 5);
        chk("stall_gap_count", gap_q.size(), 2);
        if (gap_q.size() >= 2) chk("stall_gap_len", gap_q[1], 5);

        run_frame("l5", pl5, -1, 0);

        // Back-to-back empty messages with payload_valid held across the gap.
        wait_idle();
        gap_q.delete();
        hs0 = hs_count;
        fd0 = fd_count;
        push_frame(pl0);
        push_frame(pl0);
        drive(pl0x2, -1, 0, -1);
        wait_fd("b2b", fd0 + 2);
        chk("b2b_wire_bytes", hs_count - hs0, 2 * (8 + 14 + 2 + 4));
        chk("b2b_sb_drained", exp_q.size(), 0);
        chk("b2b_gap_count", gap_q.size(), 2);
        if (gap_q.size() >= 2) chk("b2b_ifg_len", gap_q[1], IFG_CYCLES);

        // Reset in the middle of the payload, then a clean frame.
        wait_idle();
        fd0 = fd_count;
        push_frame(pl3);
        drive(pl3, -1, 0, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_tx_valid",      {31'd0, bus_if.tx_valid},      32'd0);
        chk("midreset_busy",          {31'd0, bus_if.busy},          32'd0);
        chk("midreset_payload_ready", {31'd0, bus_if.payload_ready}, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midreset_no_frame_done", fd_count, fd0);
        run_frame("after_reset", pl3, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
